// File: rtl/meas_pkg.sv
// Shared constants, state encoding and BCD helpers for the frequency/period
// display formatter.
package meas_pkg;

  localparam int VAL_W   = 40;
  localparam int BCD_DIG = 12;
  localparam int BCD_W   = 4 * BCD_DIG;

  localparam logic [1:0] UNIT_HZ  = 2'd0;
  localparam logic [1:0] UNIT_KHZ = 2'd1;
  localparam logic [1:0] UNIT_MHZ = 2'd2;

  localparam logic [1:0] UNIT_NS = 2'd0;
  localparam logic [1:0] UNIT_US = 2'd1;
  localparam logic [1:0] UNIT_MS = 2'd2;
  localparam logic [1:0] UNIT_S  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIV    = 3'd1,
    ST_BCD    = 3'd2,
    ST_ROUND  = 3'd3,
    ST_SELECT = 3'd4
  } state_t;

  // Index of the most significant nonzero digit; 0 for a zero value.
  function automatic logic [3:0] msd_index(input logic [BCD_W-1:0] v);
    logic [3:0] p;
    p = 4'd0;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (v[4*i +: 4] != 4'd0) p = 4'(i);
    end
    return p;
  endfunction

  function automatic logic [3:0] low_index(input logic [3:0] p, input int digits);
    return (int'(p) >= digits) ? 4'(int'(p) - digits + 1) : 4'd0;
  endfunction

  // Add 5 at digit lo-1 and ripple the decimal carry upward.
  function automatic logic [BCD_W-1:0] round_bcd(input logic [BCD_W-1:0] v,
                                                 input logic [3:0] lo);
    logic [BCD_W-1:0] r;
    logic             c;
    logic [4:0]       s;
    r = v;
    c = 1'b0;
    if (lo != 4'd0) begin
      for (int i = 0; i < BCD_DIG; i++) begin
        s = {1'b0, v[4*i +: 4]} + ((i == int'(lo) - 1) ? 5'd5 : 5'd0) + {4'd0, c};
        if (s > 5'd9) begin
          r[4*i +: 4] = 4'(s - 5'd10);
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = s[3:0];
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // One double-dabble step: add 3 to digits >= 5, then shift in the next bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                   input logic b);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return (adj << 1) | BCD_W'(b);
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary to BCD converter: VAL_W cycles from start (the start cycle
// performs the first step), done stays high until the next start.
module bin2bcd_serial
  import meas_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  logic [VAL_W-1:0] bin_q;
  logic [5:0]       count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd     <= '0;
      bin_q   <= '0;
      count_q <= '0;
      done    <= 1'b0;
    end else if (start) begin
      bcd     <= dabble_step('0, value[VAL_W-1]);
      bin_q   <= value << 1;
      count_q <= 6'(VAL_W - 1);
      done    <= 1'b0;
    end else if (count_q != 6'd0) begin
      bcd     <= dabble_step(bcd, bin_q[VAL_W-1]);
      bin_q   <= bin_q << 1;
      count_q <= count_q - 6'd1;
      done    <= (count_q == 6'd1);
    end
  end

endmodule

// File: rtl/meas_autorange_formatter.sv
// Turns a measured period count into auto-ranged BCD frequency and period
// readings with a fixed 82-cycle latency from start to out_valid.
module meas_autorange_formatter
  import meas_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int CNT_W      = 32,
  parameter int DIGITS     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    period_cnt,
  output logic                busy,
  output logic                out_valid,
  output logic                err,
  output logic [4*DIGITS-1:0] freq_digits,
  output logic [2:0]          freq_point,
  output logic [1:0]          freq_unit,
  output logic [4*DIGITS-1:0] period_digits,
  output logic [2:0]          period_point,
  output logic [1:0]          period_unit
);

  localparam int     DW         = 4 * DIGITS;
  localparam longint NS_PER     = longint'(1000000000) / longint'(CLOCK_FREQ);
  localparam longint DIVIDEND_L = longint'(CLOCK_FREQ) * 1000;
  localparam longint MAX_P      = ((longint'(1) << CNT_W) - 1) * NS_PER;
  localparam logic [VAL_W-1:0] DIVIDEND = VAL_W'(DIVIDEND_L);
  localparam logic [VAL_W-1:0] NS_PER_V = VAL_W'(NS_PER);
  localparam logic [5:0]       LAST_STEP = 6'(VAL_W - 1);

  if (longint'(1000000000) % longint'(CLOCK_FREQ) != 0) begin : g_bad_clock
    $error("CLOCK_FREQ must divide 1e9 exactly");
  end
  if (DIVIDEND_L >= 64'd1000000000000 || MAX_P >= 64'd1000000000000) begin : g_bad_range
    $error("values must stay below 1e12 to fit 12 BCD digits");
  end
  if (DIGITS < 4 || DIGITS > 8) begin : g_bad_digits
    $error("DIGITS must be in 4..8");
  end

  state_t           state_q, state_d;
  logic [5:0]       cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] rem_q;
  logic [VAL_W-1:0] quo_q;
  logic [VAL_W-1:0] pns_q;
  logic [BCD_W-1:0] f_bcd, p_bcd, f_rnd_q, p_rnd_q;
  logic             f_done, p_done, bcd_start;

  // Restoring division step: quo_q shifts dividend bits out and quotient bits in.
  logic [CNT_W:0]   rem_sh, diff;
  logic             ge;
  logic [CNT_W-1:0] rem_nx;

  always_comb begin
    rem_sh = {rem_q, quo_q[VAL_W-1]};
    diff   = rem_sh - {1'b0, div_q};
    ge     = ~diff[CNT_W];
    rem_nx = ge ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_DIV;
      ST_DIV:    if (cnt_q == LAST_STEP) state_d = ST_BCD;
      ST_BCD:    if (cnt_q == LAST_STEP) state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_SELECT;
      ST_SELECT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign bcd_start = (state_q == ST_BCD) && (cnt_q == 6'd0) && !err_q;

  bin2bcd_serial u_freq_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bcd_start),
    .value (quo_q),
    .bcd   (f_bcd),
    .done  (f_done)
  );

  bin2bcd_serial u_period_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bcd_start),
    .value (pns_q),
    .bcd   (p_bcd),
    .done  (p_done)
  );

  // Range selection on the rounded values.
  logic [3:0]    f_p, f_lo, f_exp, p_p, p_lo, p_exp;
  logic [1:0]    f_unit_n, p_unit_n;
  logic [DW-1:0] f_dig_n, p_dig_n;

  always_comb begin
    f_p   = msd_index(f_rnd_q);
    f_lo  = low_index(f_p, DIGITS);
    p_p   = msd_index(p_rnd_q);
    p_lo  = low_index(p_p, DIGITS);
    f_unit_n = UNIT_MHZ;
    f_exp    = 4'd9;
    if (f_p < 4'd6) begin
      f_unit_n = UNIT_HZ;
      f_exp    = 4'd3;
    end else if (f_p < 4'd9) begin
      f_unit_n = UNIT_KHZ;
      f_exp    = 4'd6;
    end
    p_unit_n = UNIT_S;
    p_exp    = 4'd9;
    if (p_p < 4'd3) begin
      p_unit_n = UNIT_NS;
      p_exp    = 4'd0;
    end else if (p_p < 4'd6) begin
      p_unit_n = UNIT_US;
      p_exp    = 4'd3;
    end else if (p_p < 4'd9) begin
      p_unit_n = UNIT_MS;
      p_exp    = 4'd6;
    end
    f_dig_n = DW'(f_rnd_q >> {f_lo, 2'b00});
    p_dig_n = DW'(p_rnd_q >> {p_lo, 2'b00});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      err_q         <= 1'b0;
      div_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      pns_q         <= '0;
      f_rnd_q       <= '0;
      p_rnd_q       <= '0;
      out_valid     <= 1'b0;
      err           <= 1'b0;
      freq_digits   <= '0;
      freq_point    <= '0;
      freq_unit     <= '0;
      period_digits <= '0;
      period_point  <= '0;
      period_unit   <= '0;
    end else begin
      cnt_q     <= (state_q == ST_IDLE || state_d != state_q) ? 6'd0 : cnt_q + 6'd1;
      out_valid <= (state_q == ST_SELECT);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            div_q <= period_cnt;
            err_q <= (period_cnt == '0);
            rem_q <= '0;
            quo_q <= DIVIDEND;
            pns_q <= VAL_W'(period_cnt) * NS_PER_V;
          end
        end
        ST_DIV: begin
          if (!err_q) begin
            rem_q <= rem_nx;
            quo_q <= {quo_q[VAL_W-2:0], ge};
          end
        end
        ST_ROUND: begin
          // Zero-period runs never start the converters, so stale BCD is discarded.
          f_rnd_q <= (f_done && !err_q) ? round_bcd(f_bcd, low_index(msd_index(f_bcd), DIGITS)) : '0;
          p_rnd_q <= (p_done && !err_q) ? round_bcd(p_bcd, low_index(msd_index(p_bcd), DIGITS)) : '0;
        end
        ST_SELECT: begin
          err <= err_q;
          if (err_q) begin
            freq_digits   <= '0;
            freq_point    <= '0;
            freq_unit     <= '0;
            period_digits <= '0;
            period_point  <= '0;
            period_unit   <= '0;
          end else begin
            freq_digits   <= f_dig_n;
            freq_point    <= 3'(f_exp - f_lo);
            freq_unit     <= f_unit_n;
            period_digits <= p_dig_n;
            period_point  <= 3'(p_exp - p_lo);
            period_unit   <= p_unit_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_meas_autorange_formatter.sv
// Directed bench for meas_autorange_formatter at 50 MHz, 4 displayed digits.
module tb_meas_autorange_formatter;

  localparam int CNT_W  = 32;
  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] period_cnt = '0;
  logic             busy, out_valid, err;
  logic [DW-1:0]    freq_digits, period_digits;
  logic [2:0]       freq_point, period_point;
  logic [1:0]       freq_unit, period_unit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  meas_autorange_formatter #(
    .CLOCK_FREQ (50000000),
    .CNT_W      (CNT_W),
    .DIGITS     (DIGITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .period_cnt    (period_cnt),
    .busy          (busy),
    .out_valid     (out_valid),
    .err           (err),
    .freq_digits   (freq_digits),
    .freq_point    (freq_point),
    .freq_unit     (freq_unit),
    .period_digits (period_digits),
    .period_point  (period_point),
    .period_unit   (period_unit)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start is sampled on the posedge inside this task (edge 0).
  task automatic launch(input logic [CNT_W-1:0] v);
    @(negedge clk);
    start      = 1'b1;
    period_cnt = v;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until out_valid; optionally pulse a second start at edge ignore_at.
  task automatic wait_valid(input string tag, input int ignore_at);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check({tag, "_busy_on"}, busy, 1);
      if (out_valid) seen = 1'b1;
      if (n == ignore_at) begin
        start      = 1'b1;
        period_cnt = 3;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, n, 82);
    check({tag, "_busy_off"}, busy, 0);
  endtask

  task automatic check_result(input string tag, input logic e_err,
                              input logic [63:0] fd, input logic [63:0] fp, input logic [63:0] fu,
                              input logic [63:0] pd, input logic [63:0] pp, input logic [63:0] pu);
    check({tag, "_err"}, err, e_err);
    check({tag, "_freq_digits"}, freq_digits, fd);
    check({tag, "_freq_point"}, freq_point, fp);
    check({tag, "_freq_unit"}, freq_unit, fu);
    check({tag, "_period_digits"}, period_digits, pd);
    check({tag, "_period_point"}, period_point, pp);
    check({tag, "_period_unit"}, period_unit, pu);
    @(posedge clk);
    #1;
    check({tag, "_valid_pulse"}, out_valid, 0);
    check({tag, "_hold_freq"}, freq_digits, fd);
    check({tag, "_hold_period"}, period_digits, pd);
  endtask

  initial begin
    // Reset state
    #22;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_freq_digits", freq_digits, 0);
    check("rst_period_digits", period_digits, 0);
    check("rst_units", {freq_unit, period_unit, freq_point, period_point}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1 kHz / 1 ms
    launch(50000);
    wait_valid("c50000", 0);
    check_result("c50000", 1'b0, 16'h1000, 3, 1, 16'h1000, 3, 2);

    // 16.67 MHz / 60 ns
    launch(3);
    wait_valid("c3", 0);
    check_result("c3", 1'b0, 16'h1667, 2, 2, 16'h0060, 0, 0);

    // Rounding carry pushes 999.96 Hz into the kHz range
    launch(50002);
    wait_valid("c50002", 0);
    check_result("c50002", 1'b0, 16'h1000, 3, 1, 16'h1000, 3, 2);

    // 0.5 Hz / 2 s
    launch(100000000);
    wait_valid("c1e8", 0);
    check_result("c1e8", 1'b0, 16'h0500, 3, 0, 16'h2000, 3, 3);

    // Zero period count
    launch(0);
    wait_valid("c0", 0);
    check_result("c0", 1'b1, 0, 0, 0, 0, 0, 0);

    // Second start during DIV must be ignored
    launch(50000);
    wait_valid("ign", 10);
    check_result("ign", 1'b0, 16'h1000, 3, 1, 16'h1000, 3, 2);

    // Reset in the middle of BCD conversion
    launch(3);
    repeat (50) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_freq_digits", freq_digits, 0);
    check("midrst_period_digits", period_digits, 0);
    check("midrst_units", {freq_unit, period_unit, freq_point, period_point}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(50000);
    wait_valid("post_rst", 0);
    check_result("post_rst", 1'b0, 16'h1000, 3, 1, 16'h1000, 3, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
